// File: rtl/xnor_kernel_feeder_if.sv
// Stream and XNOR-side signal bundle for xnor_kernel_feeder.
// The master view belongs to the feeder; the slave view belongs to whatever surrounds it.
interface xnor_kernel_feeder_if #(
    parameter int KERNEL_SIZE = 16,
    parameter int NUM_PIXELS  = 8
);
    logic                   w_valid;
    logic [KERNEL_SIZE-1:0] w_data;
    logic                   w_ready;
    logic                   pix_valid;
    logic [KERNEL_SIZE-1:0] pix_data;
    logic                   pix_ready;
    logic                   weight_wr;
    logic [KERNEL_SIZE-1:0] weight_in;
    logic                   input_plugin;
    logic [KERNEL_SIZE-1:0] pixels_in;
    logic                   xn_ready;
    logic                   xn_result;
    logic                   res_valid;
    logic [NUM_PIXELS-1:0]  res_word;
    logic                   res_ready;
    logic                   err_out;

    modport master (
        input  w_valid, w_data, pix_valid, pix_data, xn_ready, xn_result, res_ready,
        output w_ready, pix_ready, weight_wr, weight_in, input_plugin, pixels_in,
        output res_valid, res_word, err_out
    );

    modport slave (
        output w_valid, w_data, pix_valid, pix_data, xn_ready, xn_result, res_ready,
        input  w_ready, pix_ready, weight_wr, weight_in, input_plugin, pixels_in,
        input  res_valid, res_word, err_out
    );
endinterface

// File: rtl/xnor_kernel_feeder.sv
// Feeds one weight plus a job of NUM_PIXELS pixel vectors to an XNOR popcount unit
// and packs the 1-bit results into a word returned over valid/ready.
module xnor_kernel_feeder #(
    parameter int KERNEL_SIZE = 16,
    parameter int NUM_PIXELS  = 8
) (
    input  logic                clock,
    input  logic                reset,
    xnor_kernel_feeder_if.master bus
);
    localparam int CW = $clog2(NUM_PIXELS + 1);
    localparam logic [CW-1:0] LAST = CW'(NUM_PIXELS);

    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, OUT} state_t;

    state_t                 state;
    logic [CW-1:0]          issue_cnt;
    logic [CW-1:0]          result_cnt;
    logic [CW-1:0]          outstanding;
    logic [CW-1:0]          result_next;
    logic                   weight_loaded;
    logic                   pix_fire;
    logic                   capture;

    logic                   weight_wr_q;
    logic [KERNEL_SIZE-1:0] weight_in_q;
    logic                   input_plugin_q;
    logic [KERNEL_SIZE-1:0] pixels_in_q;
    logic                   res_valid_q;
    logic [NUM_PIXELS-1:0]  res_word_q;
    logic                   err_q;

    assign bus.w_ready   = (state == IDLE);
    assign bus.pix_ready = (state == STREAM) && (issue_cnt < LAST);

    assign pix_fire    = bus.pix_valid && bus.pix_ready;
    assign outstanding = issue_cnt - result_cnt;
    assign capture     = bus.xn_ready && (outstanding != '0);
    assign result_next = result_cnt + CW'(capture);

    assign bus.weight_wr    = weight_wr_q;
    assign bus.weight_in    = weight_in_q;
    assign bus.input_plugin = input_plugin_q;
    assign bus.pixels_in    = pixels_in_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_word     = res_word_q;
    assign bus.err_out      = err_q;

    // Sequencing, result capture and error tracking share one register block.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            issue_cnt      <= '0;
            result_cnt     <= '0;
            weight_loaded  <= 1'b0;
            weight_wr_q    <= 1'b0;
            weight_in_q    <= '0;
            input_plugin_q <= 1'b0;
            pixels_in_q    <= '0;
            res_valid_q    <= 1'b0;
            res_word_q     <= '0;
            err_q          <= 1'b0;
        end else begin
            weight_wr_q    <= 1'b0;
            input_plugin_q <= pix_fire;
            if (pix_fire) begin
                pixels_in_q <= bus.pix_data;
                issue_cnt   <= issue_cnt + CW'(1);
            end

            // A result with nothing in flight is dropped and flagged, never packed.
            if (capture) begin
                for (int i = 0; i < NUM_PIXELS; i++) begin
                    if (result_cnt == CW'(i)) res_word_q[i] <= bus.xn_result;
                end
                result_cnt <= result_next;
            end else if (bus.xn_ready) begin
                err_q <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.w_valid) begin
                        weight_in_q <= bus.w_data;
                        weight_wr_q <= 1'b1;
                        state       <= LOAD_W;
                    end else if (bus.pix_valid && weight_loaded) begin
                        state <= STREAM;
                    end
                end
                LOAD_W: begin
                    weight_loaded <= 1'b1;
                    state         <= STREAM;
                end
                STREAM: begin
                    if (pix_fire && (issue_cnt == LAST - CW'(1))) state <= DRAIN;
                end
                DRAIN: begin
                    if (result_next == LAST) begin
                        res_valid_q <= 1'b1;
                        state       <= OUT;
                    end
                end
                OUT: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        res_word_q  <= '0;
                        issue_cnt   <= '0;
                        result_cnt  <= '0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xnor_kernel_feeder.sv
// Directed bench for xnor_kernel_feeder with a 1-cycle XNOR popcount model attached.
module tb_xnor_kernel_feeder;
    localparam int K = 16;
    localparam int N = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    xnor_kernel_feeder_if #(.KERNEL_SIZE(K), .NUM_PIXELS(N)) bus ();

    xnor_kernel_feeder #(.KERNEL_SIZE(K), .NUM_PIXELS(N)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Attached XNOR unit: registers weight, answers one cycle after input_plugin.
    logic [K-1:0] model_w;
    logic         model_ready;
    logic         model_result;
    logic         force_ready;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            model_w      <= '0;
            model_ready  <= 1'b0;
            model_result <= 1'b0;
        end else begin
            if (bus.weight_wr) model_w <= bus.weight_in;
            model_ready <= bus.input_plugin;
            if (bus.input_plugin)
                model_result <= ($countones(~(model_w ^ bus.pixels_in)) >= K / 2);
        end
    end

    assign bus.xn_ready  = model_ready | force_ready;
    assign bus.xn_result = model_result;

    // Passive monitor of the XNOR-side strobes, sampled on the falling edge.
    int   cyc = 0;
    int   wr_cnt = 0;
    int   plugin_cnt = 0;
    int   plugin_err = 0;
    int   wr_cyc = 0;
    int   wr_gap = -1;
    logic wr_armed = 1'b0;
    logic hs_prev = 1'b0;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (reset) begin
            hs_prev = 1'b0;
        end else begin
            if (bus.input_plugin !== hs_prev) plugin_err++;
            if (bus.input_plugin) plugin_cnt++;
            if (bus.weight_wr) begin
                wr_cnt++;
                wr_cyc   = cyc;
                wr_armed = 1'b1;
            end
            if (bus.input_plugin && wr_armed) begin
                wr_gap   = cyc - wr_cyc;
                wr_armed = 1'b0;
            end
            hs_prev = bus.pix_valid && bus.pix_ready;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_weight(input logic [K-1:0] w);
        int n = 0;
        bus.w_valid = 1'b1;
        bus.w_data  = w;
        while (!bus.w_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check_output("w_ready_timeout", 32'd1, 32'd0);
        tick();
        bus.w_valid = 1'b0;
    endtask

    // Leaves pix_valid high so consecutive calls stream back-to-back.
    task automatic send_pixel(input logic [K-1:0] p);
        int n = 0;
        bus.pix_valid = 1'b1;
        bus.pix_data  = p;
        while (!bus.pix_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check_output("pix_ready_timeout", 32'd1, 32'd0);
        tick();
    endtask

    task automatic wait_result(output int n);
        n = 0;
        while (!bus.res_valid && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check_output("res_valid_timeout", 32'd1, 32'd0);
    endtask

    task automatic release_result();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    logic [K-1:0] job1 [4] = '{16'hFFFF, 16'h0000, 16'h00FF, 16'h007F};
    logic [K-1:0] job4 [4] = '{16'h0F0F, 16'hF0F0, 16'h0F0F, 16'hF0F0};

    initial begin
        int lat;
        int bad;
        int wr_base, plug_base, perr_base;

        bus.w_valid   = 1'b0;
        bus.w_data    = '0;
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        bus.res_ready = 1'b0;
        force_ready   = 1'b0;

        tick();
        tick();
        check_output("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check_output("rst_res_word", 32'(bus.res_word), 32'd0);
        check_output("rst_err_out", 32'(bus.err_out), 32'd0);
        check_output("rst_weight_wr", 32'(bus.weight_wr), 32'd0);
        check_output("rst_pix_ready", 32'(bus.pix_ready), 32'd0);
        reset = 1'b0;
        tick();

        $display("[TB] job with fresh weight 0xFFFF");
        wr_base = wr_cnt; plug_base = plugin_cnt; perr_base = plugin_err;
        send_weight(16'hFFFF);
        for (int i = 0; i < N; i++) send_pixel(job1[i]);
        bus.pix_valid = 1'b0;
        wait_result(lat);
        check_output("t1_latency", 32'(lat), 32'd2);
        check_output("t1_res_word", 32'(bus.res_word), 32'h5);
        check_output("t1_weight_wr_count", 32'(wr_cnt - wr_base), 32'd1);
        check_output("t1_wr_before_plugin", 32'(wr_gap >= 1), 32'd1);
        check_output("t1_plugin_count", 32'(plugin_cnt - plug_base), 32'd4);
        check_output("t1_plugin_align", 32'(plugin_err - perr_base), 32'd0);

        $display("[TB] result backpressure");
        bad = 0;
        bus.w_valid   = 1'b1;
        bus.pix_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (bus.res_valid !== 1'b1 || bus.res_word !== 4'b0101 ||
                bus.w_ready !== 1'b0 || bus.pix_ready !== 1'b0) bad++;
            tick();
        end
        bus.w_valid   = 1'b0;
        bus.pix_valid = 1'b0;
        check_output("t3_hold_stable", 32'(bad), 32'd0);
        check_output("t3_no_weight_wr", 32'(wr_cnt - wr_base), 32'd1);
        release_result();
        check_output("t3_res_valid_clr", 32'(bus.res_valid), 32'd0);
        check_output("t3_res_word_clr", 32'(bus.res_word), 32'd0);
        check_output("t3_back_in_idle", 32'(bus.w_ready), 32'd1);

        $display("[TB] weight reuse");
        wr_base = wr_cnt;
        for (int i = 0; i < N; i++) send_pixel(16'h0000);
        bus.pix_valid = 1'b0;
        wait_result(lat);
        check_output("t2_res_valid", 32'(bus.res_valid), 32'd1);
        check_output("t2_res_word", 32'(bus.res_word), 32'h0);
        check_output("t2_weight_wr_count", 32'(wr_cnt - wr_base), 32'd0);
        release_result();

        $display("[TB] gapped pixels with weight 0x0F0F");
        wr_base = wr_cnt; plug_base = plugin_cnt; perr_base = plugin_err;
        send_weight(16'h0F0F);
        for (int i = 0; i < N; i++) begin
            send_pixel(job4[i]);
            bus.pix_valid = 1'b0;
            tick();
        end
        wait_result(lat);
        check_output("t4_res_word", 32'(bus.res_word), 32'h5);
        check_output("t4_plugin_count", 32'(plugin_cnt - plug_base), 32'd4);
        check_output("t4_plugin_align", 32'(plugin_err - perr_base), 32'd0);
        check_output("t4_weight_wr_count", 32'(wr_cnt - wr_base), 32'd1);
        release_result();

        $display("[TB] spurious xn_ready in idle");
        force_ready = 1'b1;
        tick();
        force_ready = 1'b0;
        check_output("t5_err_set", 32'(bus.err_out), 32'd1);
        check_output("t5_res_word", 32'(bus.res_word), 32'd0);
        check_output("t5_res_valid", 32'(bus.res_valid), 32'd0);
        repeat (3) tick();
        check_output("t5_err_sticky", 32'(bus.err_out), 32'd1);

        $display("[TB] reset in the middle of a job");
        send_weight(16'hFFFF);
        send_pixel(16'hFFFF);
        send_pixel(16'h00FF);
        check_output("t6_plugin_before_rst", 32'(bus.input_plugin), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_output("t6_input_plugin", 32'(bus.input_plugin), 32'd0);
        check_output("t6_pixels_in", 32'(bus.pixels_in), 32'd0);
        check_output("t6_weight_in", 32'(bus.weight_in), 32'd0);
        check_output("t6_err_out", 32'(bus.err_out), 32'd0);
        check_output("t6_pix_ready", 32'(bus.pix_ready), 32'd0);
        check_output("t6_res_valid", 32'(bus.res_valid), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        plug_base = plugin_cnt;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.pix_ready !== 1'b0) bad++;
        end
        bus.pix_valid = 1'b0;
        check_output("t6_no_pix_accept", 32'(bad), 32'd0);
        check_output("t6_no_plugin", 32'(plugin_cnt - plug_base), 32'd0);
        check_output("t6_still_idle", 32'(bus.w_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
